// File: rtl/gsim_row_sched_if.sv
// Handshake/bus bundle between the Gauss-Seidel row scheduler and its datapath.
// The `converged` flag exists only when GSIM_EARLY_EXIT_EN is defined.
interface gsim_row_sched_if #(
  parameter int RW = 4
);
  logic          start;
  logic          abort;
  logic [31:0]   tol;
  logic [31:0]   wb_delta;
  logic          issue;
  logic [RW-1:0] row;
  logic [5:0]    nbr_mask;
  logic          wb_en;
  logic          rd_en;
  logic          out_valid;
  logic          done;
  logic [7:0]    iter_cnt;
  logic          busy;
`ifdef GSIM_EARLY_EXIT_EN
  logic          converged;
`endif

  modport master (
    input  start, abort, tol, wb_delta,
    output issue, row, nbr_mask, wb_en, rd_en, out_valid, done, iter_cnt, busy
`ifdef GSIM_EARLY_EXIT_EN
    , output converged
`endif
  );

  modport slave (
    output start, abort, tol, wb_delta,
    input  issue, row, nbr_mask, wb_en, rd_en, out_valid, done, iter_cnt, busy
`ifdef GSIM_EARLY_EXIT_EN
    , input converged
`endif
  );
endinterface

// File: rtl/gsim_row_sched.sv
// Row/iteration scheduler for the Gauss-Seidel PE: one row in flight, banded +-3 masks,
// read-out after the last iteration. GSIM_EARLY_EXIT_EN enables convergence-based exit.
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | one row in flight, down-counter from PE_LAT to write-back
// OUT     | N read cycles of x[0..N-1]
// DRAIN   | last read returning, done pulses
module gsim_row_sched #(
  parameter int N        = 16,
  parameter int MAX_ITER = 80,
  parameter int PE_LAT   = 2
) (
  input logic              clk,
  input logic              reset,
  gsim_row_sched_if.master bus
);
  localparam int RW = $clog2(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [2:0]    tmr;
  logic [RW-1:0] cur_row;
  logic [RW-1:0] nxt_row;
  logic [RW-1:0] wb_row_q;
  logic [RW-1:0] row_q;
  logic [5:0]    mask_q;
  logic [7:0]    iter_q;
  logic          issue_q, wb_q, rd_q, ov_q, done_q;
  logic          early_ok;
  logic          final_now;
  logic          last_iter_wb;

  function automatic logic [5:0] mask_of(input logic [RW-1:0] r);
    int ri;
    ri = int'(r);
    return {ri <= N-4, ri >= 3, ri <= N-3, ri >= 2, ri <= N-2, ri >= 1};
  endfunction

  always_comb begin
    nxt_row = (cur_row == RW'(N-1)) ? '0 : cur_row + 1'b1;
  end

`ifdef GSIM_EARLY_EXIT_EN
  logic conv_q;
  logic converged_q;
  // Row 0's write-back restarts the per-iteration flag.
  assign early_ok      = ((wb_row_q == '0) | conv_q) & (bus.wb_delta <= bus.tol);
  assign bus.converged = converged_q;
`else
  logic unused_cfg;
  assign early_ok   = 1'b0;
  assign unused_cfg = ^{bus.tol, bus.wb_delta};
`endif

  // The iteration limit is known one row ahead, so no speculative issue follows the final write-back.
  assign last_iter_wb = (cur_row == RW'(N-1)) && ((9'(iter_q) + 9'd1) == 9'(MAX_ITER));
  assign final_now    = wb_q && (wb_row_q == RW'(N-1)) &&
                        ((iter_q == 8'(MAX_ITER)) || early_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tmr      <= '0;
      cur_row  <= '0;
      wb_row_q <= '0;
      row_q    <= '0;
      mask_q   <= '0;
      iter_q   <= '0;
      issue_q  <= 1'b0;
      wb_q     <= 1'b0;
      rd_q     <= 1'b0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef GSIM_EARLY_EXIT_EN
      conv_q      <= 1'b0;
      converged_q <= 1'b0;
`endif
    end else begin
      issue_q <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      ov_q    <= rd_q;
      if (bus.abort) begin
        state   <= S_IDLE;
        ov_q    <= 1'b0;
        row_q   <= '0;
        cur_row <= '0;
        tmr     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state   <= S_CALC;
              issue_q <= 1'b1;
              row_q   <= '0;
              cur_row <= '0;
              mask_q  <= mask_of('0);
              tmr     <= 3'(PE_LAT - 1);
              iter_q  <= '0;
`ifdef GSIM_EARLY_EXIT_EN
              conv_q      <= 1'b0;
              converged_q <= 1'b0;
`endif
            end
          end
          S_CALC: begin
            if (final_now) begin
              state   <= S_OUT;
              rd_q    <= 1'b1;
              row_q   <= '0;
              cur_row <= '0;
`ifdef GSIM_EARLY_EXIT_EN
              converged_q <= early_ok && (iter_q != 8'(MAX_ITER));
`endif
            end else begin
`ifdef GSIM_EARLY_EXIT_EN
              if (wb_q) conv_q <= early_ok;
`endif
              if (tmr == '0) begin
                wb_q     <= 1'b1;
                wb_row_q <= cur_row;
                if (cur_row == RW'(N-1)) iter_q <= iter_q + 8'd1;
                if (!last_iter_wb) begin
                  issue_q <= 1'b1;
                  row_q   <= nxt_row;
                  cur_row <= nxt_row;
                  mask_q  <= mask_of(nxt_row);
                  tmr     <= 3'(PE_LAT - 1);
                end else begin
                  row_q <= cur_row;
                end
              end else begin
                tmr <= tmr - 3'd1;
              end
            end
          end
          S_OUT: begin
            if (cur_row == RW'(N-1)) begin
              state  <= S_DRAIN;
              done_q <= 1'b1;
            end else begin
              rd_q    <= 1'b1;
              row_q   <= nxt_row;
              cur_row <= nxt_row;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.issue     = issue_q;
  assign bus.row       = row_q;
  assign bus.nbr_mask  = mask_q;
  assign bus.wb_en     = wb_q;
  assign bus.rd_en     = rd_q;
  assign bus.out_valid = ov_q;
  assign bus.done      = done_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_gsim_row_sched.sv
// Scoreboard bench for gsim_row_sched: each accepted start expands into the expected
// event timeline; a negedge monitor pops and compares whatever the DUT presents.
module tb_gsim_row_sched;
  localparam int N  = 16;
  localparam int MI = 80;
  localparam int PL = 2;
  localparam int K_ISS = 0, K_WB = 1, K_RD = 2, K_OV = 3, K_DONE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gsim_row_sched_if #(.RW(4)) bus();
  gsim_row_sched #(.N(N), .MAX_ITER(MI), .PE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct {int c; int r;} ev_t;
  ev_t q[5][$];
  string kname[5] = '{"issue", "wb_en", "rd_en", "out_valid", "done"};

  int cyc = 0;
  int errors = 0, checks = 0;
  int busy_lo = 0, busy_hi = -1;
  bit exp_conv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] mask_ref(input int r);
    logic [5:0] m;
    int offs[6] = '{-1, 1, -2, 2, -3, 3};
    for (int i = 0; i < 6; i++) m[i] = (r + offs[i] >= 0) && (r + offs[i] <= N - 1);
    return m;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void purge(input int after);
    for (int k = 0; k < 5; k++)
      while (q[k].size() > 0 && q[k][$].c > after) void'(q[k].pop_back());
  endfunction

  // Timeline of one solve started at cycle s running nit iterations.
  function automatic void plan_solve(input int s, input int nit, input bit extra, input bit conv);
    int t;
    t = s + 1 + nit * N * PL;
    for (int k = 0; k < nit * N; k++) begin
      q[K_ISS].push_back('{s + 1 + k * PL, k % N});
      q[K_WB].push_back('{s + 1 + (k + 1) * PL, k % N});
    end
    if (extra) q[K_ISS].push_back('{t, 0});
    for (int j = 0; j < N; j++) begin
      q[K_RD].push_back('{t + 1 + j, j});
      q[K_OV].push_back('{t + 2 + j, j});
    end
    q[K_DONE].push_back('{t + N + 1, nit});
    busy_lo  = s;
    busy_hi  = t + N + 1;
    exp_conv = conv;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nit, input bit extra, input bit conv);
    bit acc;
    acc = !(cyc > busy_lo && cyc <= busy_hi);
    bus.start = 1'b1;
    if (acc) plan_solve(cyc, nit, extra, conv);
    tick(1);
    bus.start = 1'b0;
    if (acc) chk("iter_clear", bus.iter_cnt, 0);
  endtask

  task automatic do_abort(input bit with_start);
    bus.abort = 1'b1;
    bus.start = with_start;
    purge(cyc);
    if (busy_hi > cyc) busy_hi = cyc;
    tick(1);
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic match(input int k, input bit fired, input int rowv);
    while (q[k].size() > 0 && q[k][0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_missing: expected at cycle %0d row %0d, not seen by cycle %0d",
               kname[k], q[k][0].c, q[k][0].r, cyc);
      void'(q[k].pop_front());
    end
    if (fired) begin
      if (q[k].size() == 0 || q[k][0].c != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: asserted at cycle %0d row %0d, none expected", kname[k], cyc, rowv);
      end else begin
        if (k == K_ISS) begin
          chk("issue_row", rowv, q[k][0].r);
          chk("nbr_mask", bus.nbr_mask, mask_ref(q[k][0].r));
        end else if (k == K_WB || k == K_RD) begin
          chk({kname[k], "_row"}, rowv, q[k][0].r);
        end else if (k == K_DONE) begin
          chk("done_iter_cnt", bus.iter_cnt, q[k][0].r);
`ifdef GSIM_EARLY_EXIT_EN
          chk("converged", bus.converged, exp_conv);
`endif
        end else begin
          checks++;
        end
        void'(q[k].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    int r, wr;
    r  = int'(bus.row);
    wr = bus.issue ? (r + N - 1) % N : r;
    match(K_ISS, bus.issue, r);
    match(K_WB, bus.wb_en, wr);
    match(K_RD, bus.rd_en, r);
    match(K_OV, bus.out_valid, r);
    match(K_DONE, bus.done, r);
    if (!bus.issue) chk("mask_idle", bus.nbr_mask, 0);
    chk("busy", bus.busy, (cyc > busy_lo && cyc <= busy_hi));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.tol = 32'd0;
    bus.wb_delta = 32'd1;
    tick(1);
    chk("rst_issue", bus.issue, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_iter", bus.iter_cnt, 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Nominal solve with stray starts while busy.
    do_start(MI, 0, 0);
    repeat (4) begin
      tick($urandom_range(20, 500));
      do_start(MI, 0, 0);
    end
    tick(busy_hi + 2 - cyc);

    // Random aborts, then an abort that outranks a same-cycle start in IDLE.
    repeat (3) begin
      do_start(MI, 0, 0);
      tick($urandom_range(5, 400));
      do_abort(0);
      tick($urandom_range(1, 6));
    end
    do_abort(1);
    tick(3);

    // Abort 100 cycles into CALC, restart 5 cycles later.
    do_start(MI, 0, 0);
    tick(99);
    do_abort(0);
    chk("abort_busy", bus.busy, 0);
    tick(4);
    do_start(MI, 0, 0);

    // Async reset in the middle of read-out.
    s = busy_lo;
    t = s + 1 + MI * N * PL;
    tick(t + 5 - cyc);
    #2;
    reset = 1'b1;
    purge(cyc - 1);
    busy_hi = cyc - 1;
    #1;
    chk("midout_rd_en", bus.rd_en, 0);
    chk("midout_out_valid", bus.out_valid, 0);
    chk("midout_busy", bus.busy, 0);
    chk("midout_iter", bus.iter_cnt, 0);
    chk("midout_row", bus.row, 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    do_start(MI, 0, 0);
    tick(busy_hi + 2 - cyc);

`ifdef GSIM_EARLY_EXIT_EN
    bus.wb_delta = 32'd0;
    do_start(1, 1, 1);
    tick(busy_hi + 2 - cyc);
`endif

    tick(3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL %s_leftover: %0d expected events never seen", kname[k], q[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(posedge clk) begin
`ifndef GSIM_EARLY_EXIT_EN
    #1;
    bus.tol = $urandom;
    bus.wb_delta = $urandom;
`endif
  end
endmodule

// File: doc/gsim_row_sched.md
# gsim_row_sched

Row/iteration scheduler for the Gauss-Seidel solver datapath. It sequences a single shared PE over the N rows of a banded (±1, ±2, ±3) system, with one row in flight at a time. It generates per-row neighbour-enable masks, write-back strobes and the iteration count. After the final iteration it drives the result read-out. It sits between the top-level input/output handshake and the x/b storage plus PE.

## Interface

Parameters:
- N, 16: number of rows/unknowns; N ≥ 4.
- MAX_ITER, 80: iteration limit, 1..255.
- PE_LAT, 2: cycles from row issue to PE result valid, 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin a solve; honoured only in IDLE (b already loaded)
- abort  in  1  synchronous abandon; state goes to IDLE next cycle, no done
- tol  in  32  convergence threshold, unsigned (used only with GSIM_EARLY_EXIT_EN)
- wb_delta  in  32  |x_new − x_old| of the row being written back, unsigned
- issue  out  1  PE operands for row `row` are presented this cycle
- row  out  4  row index for the issue, write-back and read address (log2 N bits)
- nbr_mask  out  6  neighbour enables. Bit0 = x[r−1], bit1 = x[r+1], bit2 = x[r−2], bit3 = x[r+2], bit4 = x[r−3], bit5 = x[r+3].
- wb_en  out  1  write PE result into x[row]
- rd_en  out  1  read x[row] for output (1-cycle read latency)
- out_valid  out  1  x_out from the datapath is valid
- done  out  1  one-cycle pulse at end of solve
- iter_cnt  out  8  completed iterations
- busy  out  1  state ≠ IDLE

## Operation

- States:
  - IDLE: waits for start.
  - CALC: one row in flight, per-row countdown from PE_LAT.
  - OUT: N read cycles.
  - DRAIN: one cycle for the last read to return.
- Transitions:
  - IDLE→CALC on start.
  - CALC→OUT after the last row's write-back of the final iteration.
  - OUT→DRAIN after rd_en for row N−1.
  - DRAIN→IDLE, with done asserted in DRAIN.
- Row issue:
  - Rows are issued in order 0..N−1.
  - Row r+1 issues in the same cycle as row r's wb_en; the datapath forwards the value.
  - After row N−1's wb_en, row 0 of the next iteration issues in that same cycle, so there is no bubble at an iteration boundary.
- nbr_mask bit for offset d is 1 iff 0 ≤ r+d ≤ N−1. Examples:
  - Row 0: 6'b101010.
  - Row 1: 6'b101011.
  - Row N−1: 6'b010101.
  - Mask is 0 when issue = 0.
- iter_cnt:
  - Increments at wb_en of row N−1.
  - Clears on start.
  - Holds its value after done until the next start.
- Final iteration is the one in which iter_cnt reaches MAX_ITER, or the early-exit condition is met.
- start while busy is ignored.
- abort takes priority over every other event, including a same-cycle start or wb.
- reset: all outputs 0, state IDLE, counters 0. Reset mid-solve discards progress.

## Timing

- With start high at cycle 0:
  - Row 0 issues at cycle 1.
  - wb_en for each row comes PE_LAT cycles after its issue.
  - Each row takes PE_LAT cycles, so one iteration takes N·PE_LAT cycles.
- Last write-back occurs at cycle T = 1 + MAX_ITER·N·PE_LAT.
- Read-out:
  - rd_en is high for cycles T+1..T+N, with row = 0..N−1.
  - out_valid is high for cycles T+2..T+N+1.
  - done pulses at cycle T+N+1, coincident with the last out_valid.
  - IDLE at cycle T+N+2; a new start is accepted from that cycle.
- issue, wb_en and rd_en are registered outputs, with row valid alongside them.
- issue and wb_en are never simultaneously asserted for the same row.

## Configuration

- Macro: GSIM_EARLY_EXIT_EN.
- Defined:
  - A per-iteration convergence flag is set at row 0's write-back and ANDed with (wb_delta ≤ tol) on every write-back of the iteration.
  - If the flag is still 1 at row N−1's write-back, that iteration is final.
  - At least one iteration always runs.
  - Adds output `converged` (1 bit): set when a solve ends early, cleared on start.
- Not defined:
  - tol and wb_delta are ignored.
  - Exactly MAX_ITER iterations always run.
  - No `converged` port.

## Test plan

- Nominal (N=16, PE_LAT=2, MAX_ITER=80): start at cycle 0 → row 0 issues at cycle 1 with mask 6'b101010. wb_en at cycles 3, 5, …. Last wb at cycle 2561. rd_en cycles 2562–2577, out_valid cycles 2563–2578, done at 2578, iter_cnt=80.
- Mask sweep across all 16 rows of one iteration → row 1 = 6'b101011, row 2 = 6'b101111, rows 3..12 = 6'b111111, row 15 = 6'b010101.
- Abort at cycle 100 while in CALC → cycle 101 is IDLE with busy=0 and no done. A start at cycle 105 restarts with iter_cnt=0 and row 0 issue at cycle 106.
- Async reset asserted mid-OUT → all outputs 0 immediately. After release, start behaves as in the nominal case.
- start pulsed during CALC → ignored; timing unchanged from the nominal case.
- GSIM_EARLY_EXIT_EN, tol=0, wb_delta=0 → final write-back at cycle 33, iter_cnt=1, converged=1, done at cycle 50.
